// File: rtl/bram_capture_ctrl_if.sv
// Sample/readback and BRAM-port bundle for bram_capture_ctrl.
interface bram_capture_ctrl_if #(
  parameter int unsigned NB_ADDR = 15,
  parameter int unsigned NB_DATA = 14
) ();

  // Control and sample stream from the datapath / readout side
  logic               i_start;
  logic               i_stop;
  logic [NB_DATA-1:0] i_sample;
  logic               i_sample_valid;
  logic               i_read_req;

  // Registered read data returned by the BRAM
  logic [NB_DATA-1:0] i_ram_data;

  // BRAM write and read ports
  logic [NB_DATA-1:0] o_ram_data;
  logic [NB_ADDR-1:0] o_ram_write_addr;
  logic               o_ram_write_enable;
  logic [NB_ADDR-1:0] o_ram_read_addr;
  logic               o_ram_read_enable;

  // Readback and status
  logic [NB_DATA-1:0] o_data;
  logic               o_data_valid;
  logic               o_ready;
  logic               o_busy;
  logic [NB_ADDR:0]   o_count;
  logic               o_done;

  // Controller side
  modport slave (
    input  i_start, i_stop, i_sample, i_sample_valid, i_read_req, i_ram_data,
    output o_ram_data, o_ram_write_addr, o_ram_write_enable,
           o_ram_read_addr, o_ram_read_enable,
           o_data, o_data_valid, o_ready, o_busy, o_count, o_done
  );

  // Datapath / readout / BRAM side
  modport master (
    output i_start, i_stop, i_sample, i_sample_valid, i_read_req, i_ram_data,
    input  o_ram_data, o_ram_write_addr, o_ram_write_enable,
           o_ram_read_addr, o_ram_read_enable,
           o_data, o_data_valid, o_ready, o_busy, o_count, o_done
  );

endinterface

// File: rtl/bram_capture_ctrl.sv
// Capture-and-readback controller driving a single-clock BRAM: stores a
// stream of valid samples at consecutive addresses, then returns them one
// word per request using the BRAM's registered read port.
module bram_capture_ctrl #(
  parameter int unsigned NB_ADDR = 15,
  parameter int unsigned NB_DATA = 14
) (
  input  logic               clock,
  input  logic               i_reset,
  bram_capture_ctrl_if.slave ctrl_if
);

  localparam int unsigned    NB_CNT    = NB_ADDR + 1;
  localparam logic [NB_CNT-1:0] CNT_DEPTH = NB_CNT'(1) << NB_ADDR;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FULL,
    RD_ISSUE,
    RD_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [NB_CNT-1:0]  count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NB_DATA-1:0] wr_data_q, wr_data_d;
  logic               rd_en_q, rd_en_d;
  logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [NB_CNT-1:0]  count_inc;
  logic [NB_CNT-1:0]  rd_next_cnt;

  // Count after one more write, and words consumed after the current read
  assign count_inc   = count_q + NB_CNT'(1);
  assign rd_next_cnt = {1'b0, rd_ptr_q} + NB_CNT'(1);

  // Next-state, pointer and registered-output logic
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_if.i_start) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          state_d  = CAPTURE;
        end
      end

      CAPTURE: begin
        // A sample arriving with stop is written and counted first
        if (ctrl_if.i_sample_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_data_d = ctrl_if.i_sample;
          wr_ptr_d  = wr_ptr_q + NB_ADDR'(1);
          count_d   = count_inc;
          if (count_inc == CNT_DEPTH) begin
            state_d = FULL;
          end else if (ctrl_if.i_stop) begin
            state_d = FULL;
          end
        end else if (ctrl_if.i_stop) begin
          if (count_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FULL;
          end
        end
      end

      FULL: begin
        if (ctrl_if.i_read_req) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_ptr_q;
          state_d   = RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        // BRAM registers the addressed word on this edge
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        data_d       = ctrl_if.i_ram_data;
        data_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + NB_ADDR'(1);
        if (rd_next_cnt == count_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FULL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == FULL);
    busy_d  = (state_d == CAPTURE);
  end

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ctrl_if.o_ram_data         = wr_data_q;
  assign ctrl_if.o_ram_write_addr   = wr_addr_q;
  assign ctrl_if.o_ram_write_enable = wr_en_q;
  assign ctrl_if.o_ram_read_addr    = rd_addr_q;
  assign ctrl_if.o_ram_read_enable  = rd_en_q;
  assign ctrl_if.o_data             = data_q;
  assign ctrl_if.o_data_valid       = data_valid_q;
  assign ctrl_if.o_ready            = ready_q;
  assign ctrl_if.o_busy             = busy_q;
  assign ctrl_if.o_count            = count_q;
  assign ctrl_if.o_done             = done_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl with a behavioural BRAM attached.
module tb_bram_capture_ctrl;

  localparam int unsigned NA    = 3;
  localparam int unsigned ND    = 14;
  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic i_reset;

  always #5 clock = ~clock;

  bram_capture_ctrl_if #(.NB_ADDR(NA), .NB_DATA(ND)) bus ();

  bram_capture_ctrl #(.NB_ADDR(NA), .NB_DATA(ND)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .ctrl_if (bus)
  );

  // Behavioural single-clock BRAM with registered read data
  logic [ND-1:0] mem [DEPTH];
  logic [ND-1:0] ram_rd = '0;
  always @(posedge clock) begin
    if (bus.o_ram_write_enable) mem[bus.o_ram_write_addr] <= bus.o_ram_data;
    if (bus.o_ram_read_enable)  ram_rd <= mem[bus.o_ram_read_addr];
  end
  assign bus.i_ram_data = ram_rd;

  int checks = 0;
  int errors = 0;

  // Write log {addr, data} and strobe counters, sampled mid-cycle
  logic [NA+ND-1:0] wlog [$];
  int rd_en_cnt = 0;
  int dv_cnt    = 0;
  always @(negedge clock) begin
    if (bus.o_ram_write_enable === 1'b1) wlog.push_back({bus.o_ram_write_addr, bus.o_ram_data});
    if (bus.o_ram_read_enable === 1'b1) rd_en_cnt++;
    if (bus.o_data_valid === 1'b1) dv_cnt++;
  end

  logic [ND-1:0] model_q [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_start        = 1'b0;
    bus.i_stop         = 1'b0;
    bus.i_sample       = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_read_req     = 1'b0;
  endtask

  function automatic logic [43:0] all_outs();
    return {bus.o_ram_write_enable, bus.o_ram_write_addr, bus.o_ram_data,
            bus.o_ram_read_enable, bus.o_ram_read_addr, bus.o_data,
            bus.o_data_valid, bus.o_ready, bus.o_busy, bus.o_count, bus.o_done};
  endfunction

  // Request every word of exp and check each returns 3 cycles later in order
  task automatic readback(input string name, input logic [ND-1:0] exp[$], input bit hold, input int gap_max);
    for (int i = 0; i < exp.size(); i++) begin
      int n = 0;
      repeat ($urandom_range(0, gap_max)) step();
      while (bus.o_ready !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s ready word %0d: got %b expected 1", name, i, bus.o_ready);
        bus.i_read_req = 1'b0;
        return;
      end
      bus.i_read_req = 1'b1;
      step();
      checks++;
      if ({bus.o_ram_read_enable, bus.o_ram_read_addr} !== {1'b1, NA'(i)}) begin
        errors++;
        $display("FAIL %s rd_issue word %0d: got en=%b addr=%0d expected en=1 addr=%0d",
                 name, i, bus.o_ram_read_enable, bus.o_ram_read_addr, i);
      end
      if (!hold) bus.i_read_req = 1'b0;
      step();
      checks++;
      if ({bus.o_data_valid, bus.o_ram_read_enable} !== 2'b00) begin
        errors++;
        $display("FAIL %s early word %0d: got dv=%b re=%b expected 0 0",
                 name, i, bus.o_data_valid, bus.o_ram_read_enable);
      end
      step();
      checks++;
      if ({bus.o_data_valid, bus.o_data, bus.o_done} !== {1'b1, exp[i], 1'(i == exp.size() - 1)}) begin
        errors++;
        $display("FAIL %s data word %0d: got dv=%b data=%h done=%b expected dv=1 data=%h done=%b",
                 name, i, bus.o_data_valid, bus.o_data, bus.o_done, exp[i], (i == exp.size() - 1));
      end
      bus.i_read_req = 1'b0;
    end
    checks++;
    if ({bus.o_ready, bus.o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s end_idle: got ready=%b busy=%b expected 0 0", name, bus.o_ready, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1'b1;
    step();
    step();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    i_reset = 1'b0;
    step();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_full_capture();
    wlog.delete();
    model_q.delete();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    checks++;
    if ({bus.o_busy, bus.o_count} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL full_armed: got busy=%b count=%0d expected 1 0", bus.o_busy, bus.o_count);
    end
    for (int i = 0; i < 8; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample       = ND'(16 + i);
      model_q.push_back(ND'(16 + i));
      step();
      checks++;
      if ({bus.o_ram_write_enable, bus.o_ram_write_addr, bus.o_ram_data} !== {1'b1, NA'(i), ND'(16 + i)}) begin
        errors++;
        $display("FAIL full_write %0d: got we=%b addr=%0d data=%h expected 1 %0d %h",
                 i, bus.o_ram_write_enable, bus.o_ram_write_addr, bus.o_ram_data, i, 16 + i);
      end
    end
    checks++;
    if ({bus.o_ready, bus.o_busy, bus.o_count} !== {1'b1, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL full_state: got ready=%b busy=%b count=%0d expected 1 0 8",
               bus.o_ready, bus.o_busy, bus.o_count);
    end
    bus.i_sample = 14'h0099;
    step();
    bus.i_sample_valid = 1'b0;
    checks++;
    if (bus.o_ram_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL full_ninth: got we=%b expected 0", bus.o_ram_write_enable);
    end
    step();
    checks++;
    if (wlog.size() != 8) begin
      errors++;
      $display("FAIL full_wlog_size: got %0d expected 8", wlog.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== model_q[i]) begin
        errors++;
        $display("FAIL full_mem %0d: got %h expected %h", i, mem[i], model_q[i]);
      end
    end
  endtask

  task automatic test_readback();
    int re0 = rd_en_cnt;
    readback("readback", model_q, 1'b0, 0);
    step();
    checks++;
    if (rd_en_cnt - re0 != 8) begin
      errors++;
      $display("FAIL readback_reads: got %0d expected 8", rd_en_cnt - re0);
    end
  endtask

  task automatic test_early_stop();
    logic [ND-1:0] exp [$];
    exp = '{14'h1A, 14'h1B, 14'h1C};
    wlog.delete();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample       = exp[i];
      bus.i_stop         = (i == 2);
      step();
    end
    idle_inputs();
    checks++;
    if ({bus.o_count, bus.o_ready, bus.o_busy} !== {4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL early_state: got count=%0d ready=%b busy=%b expected 3 1 0",
               bus.o_count, bus.o_ready, bus.o_busy);
    end
    step();
    checks++;
    if (wlog.size() != 3 || wlog[2] !== {3'd2, 14'h1C}) begin
      errors++;
      $display("FAIL early_wlog: got size=%0d expected 3 ending at addr 2 data 1c", wlog.size());
    end
    readback("early_rb", exp, 1'b0, 2);
  endtask

  task automatic test_empty_stop();
    wlog.delete();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b1;
    step();
    bus.i_stop = 1'b0;
    checks++;
    if ({bus.o_done, bus.o_busy, bus.o_ready, bus.o_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL empty_done: got done=%b busy=%b ready=%b count=%0d expected 1 0 0 0",
               bus.o_done, bus.o_busy, bus.o_ready, bus.o_count);
    end
    step();
    checks++;
    if (bus.o_done !== 1'b0 || wlog.size() != 0) begin
      errors++;
      $display("FAIL empty_after: got done=%b writes=%0d expected 0 0", bus.o_done, wlog.size());
    end
  endtask

  task automatic test_ignored();
    logic [ND-1:0] exp [$];
    int re0;
    exp = '{14'h0A1, 14'h0A2, 14'h0A3, 14'h0A4};
    wlog.delete();
    bus.i_start = 1'b1;
    step();
    bus.i_start    = 1'b0;
    bus.i_read_req = 1'b1;
    re0 = rd_en_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample       = exp[i];
      bus.i_start        = (i == 2);
      step();
    end
    idle_inputs();
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    checks++;
    if ({bus.o_count, bus.o_ready} !== {4'd4, 1'b1} || rd_en_cnt != re0) begin
      errors++;
      $display("FAIL ign_capture: got count=%0d ready=%b reads=%0d expected 4 1 0",
               bus.o_count, bus.o_ready, rd_en_cnt - re0);
    end
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 14'h3FFF;
    bus.i_start        = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if (wlog.size() != 4 || wlog[3] !== {3'd3, 14'h0A4} || bus.o_count !== 4'd4) begin
      errors++;
      $display("FAIL ign_full: got writes=%0d count=%0d expected 4 4", wlog.size(), bus.o_count);
    end
    re0 = rd_en_cnt;
    readback("ign_hold_rb", exp, 1'b1, 0);
    step();
    checks++;
    if (rd_en_cnt - re0 != 4) begin
      errors++;
      $display("FAIL ign_one_read: got %0d reads expected 4", rd_en_cnt - re0);
    end
  endtask

  task automatic test_reset_mid();
    int dv0;
    logic [ND-1:0] exp [$];
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample       = ND'(14'h200 + i);
      step();
    end
    checks++;
    if (bus.o_ram_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_write: got we=%b expected 1", bus.o_ram_write_enable);
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    idle_inputs();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL rst_mid_write: got %h expected 0", all_outs());
    end
    step();
    wlog.delete();
    bus.i_start = 1'b1;
    step();
    bus.i_start        = 1'b0;
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 14'h2A0;
    step();
    bus.i_sample = 14'h2A1;
    bus.i_stop   = 1'b1;
    step();
    idle_inputs();
    bus.i_read_req = 1'b1;
    step();
    bus.i_read_req = 1'b0;
    dv0 = dv_cnt;
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL rst_mid_read: got %h expected 0", all_outs());
    end
    step();
    checks++;
    if (dv_cnt != dv0 || wlog.size() != 2 || wlog[0] !== {3'd0, 14'h2A0}) begin
      errors++;
      $display("FAIL rst_read_effects: got dv=%0d writes=%0d expected 0 2", dv_cnt - dv0, wlog.size());
    end
    wlog.delete();
    exp = '{14'h03C};
    bus.i_start = 1'b1;
    step();
    bus.i_start        = 1'b0;
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 14'h03C;
    bus.i_stop         = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if (wlog.size() != 1 || wlog[0] !== {3'd0, 14'h03C} || bus.o_count !== 4'd1) begin
      errors++;
      $display("FAIL rst_restart: got writes=%0d count=%0d expected 1 at addr 0, count 1", wlog.size(), bus.o_count);
    end
    readback("rst_restart_rb", exp, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [ND-1:0] exp [$];
      int n;
      string name;
      name = $sformatf("rand%0d", r);
      wlog.delete();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      n = $urandom_range(0, 12);
      for (int j = 0; j < n && exp.size() < DEPTH; j++) begin
        bus.i_sample_valid = ($urandom_range(0, 3) != 0);
        bus.i_sample       = ND'($urandom);
        if (bus.i_sample_valid) exp.push_back(bus.i_sample);
        step();
      end
      idle_inputs();
      if (exp.size() < DEPTH) begin
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
      end
      checks++;
      if ({bus.o_count, bus.o_ready, bus.o_done} !== {4'(exp.size()), 1'(exp.size() != 0), 1'(exp.size() == 0)}) begin
        errors++;
        $display("FAIL %s end_capture: got count=%0d ready=%b done=%b expected count=%0d",
                 name, bus.o_count, bus.o_ready, bus.o_done, exp.size());
      end
      step();
      checks++;
      if (wlog.size() != exp.size()) begin
        errors++;
        $display("FAIL %s wlog_size: got %0d expected %0d", name, wlog.size(), exp.size());
      end else begin
        for (int k = 0; k < exp.size(); k++) begin
          checks++;
          if (wlog[k] !== {NA'(k), exp[k]}) begin
            errors++;
            $display("FAIL %s write %0d: got %h expected %h", name, k, wlog[k], {NA'(k), exp[k]});
          end
        end
      end
      if (exp.size() != 0) readback(name, exp, 1'($urandom_range(0, 1)), 3);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    i_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_full_capture();
    test_readback();
    test_early_stop();
    test_empty_stop();
    test_ignored();
    test_reset_mid();
    test_random();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bram_capture_ctrl.md
# bram_capture_ctrl

Capture-and-readback controller that drives the write and read ports of the team's single-clock block RAM. It arms on a start pulse, writes a stream of valid samples to consecutive addresses until the RAM is full or capture is stopped, then returns the stored words one at a time on request. It sits between the sample datapath (for example PRBS or filter output) and the debug/readout logic, with the BRAM instantiated next to it.

## Interface
Parameters:
- NB_ADDR, 15, RAM address width; depth is 2**NB_ADDR words
- NB_DATA, 14, sample/RAM word width

Ports:
- clock  in  1  system clock, rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_start  in  1  arm capture; honoured only in IDLE
- i_stop  in  1  end capture early; honoured only in CAPTURE
- i_sample  in  NB_DATA  sample to store
- i_sample_valid  in  1  i_sample is valid this cycle
- i_read_req  in  1  request the next stored word; honoured only when o_ready=1
- i_ram_data  in  NB_DATA  BRAM registered read data
- o_ram_data  out  NB_DATA  BRAM write data
- o_ram_write_addr  out  NB_ADDR  BRAM write address
- o_ram_write_enable  out  1  BRAM write strobe
- o_ram_read_addr  out  NB_ADDR  BRAM read address
- o_ram_read_enable  out  1  BRAM read strobe
- o_data  out  NB_DATA  readback word
- o_data_valid  out  1  one-cycle pulse; o_data is valid
- o_ready  out  1  high in FULL; a read request is accepted
- o_busy  out  1  high in CAPTURE
- o_count  out  NB_ADDR+1  number of words captured
- o_done  out  1  one-cycle pulse when readback or an empty capture completes

## Operation
- States: IDLE, CAPTURE, FULL, RD_ISSUE, RD_WAIT. o_ready is high only in FULL. o_busy is high only in CAPTURE.
- Transitions:
  - IDLE: on i_start, clear wr_ptr, rd_ptr and o_count, then go to CAPTURE.
  - CAPTURE, on i_sample_valid:
    - Register o_ram_write_enable=1, o_ram_write_addr=wr_ptr, o_ram_data=i_sample.
    - Increment wr_ptr and o_count.
    - If o_count reaches 2**NB_ADDR with this write, go to FULL.
  - CAPTURE, on i_stop:
    - If o_count is 0 after this cycle's write (no write pending), go to IDLE and pulse o_done.
    - Otherwise go to FULL.
    - If i_stop and i_sample_valid occur together, the sample is written and counted first.
  - FULL: on i_read_req, register o_ram_read_enable=1 and o_ram_read_addr=rd_ptr, then go to RD_ISSUE.
  - RD_ISSUE: deassert o_ram_read_enable and go to RD_WAIT.
  - RD_WAIT:
    - Register o_data=i_ram_data, pulse o_data_valid and increment rd_ptr.
    - If rd_ptr+1 equals o_count, go to IDLE and pulse o_done together with o_data_valid.
    - Otherwise go back to FULL.
- Ignored inputs:
  - i_start outside IDLE, i_stop outside CAPTURE, and i_read_req outside FULL.
  - i_sample_valid outside CAPTURE (no write occurs).
- Write strobe: o_ram_write_enable is a one-cycle pulse per accepted sample and never fires outside CAPTURE.
- Pointers: wr_ptr and rd_ptr are NB_ADDR bits wide and wrap naturally; a wrapped wr_ptr coincides with the FULL transition. o_count is held until the next i_start.

## Timing
- Reset values: every output is 0 and the state is IDLE. On a reset edge during a write or read, the strobes are low in the following cycle. Reset does not alter RAM contents.
- Write latency: a sample accepted at edge k produces write_enable, addr and data high/valid after edge k; the BRAM writes at edge k+1.
- Read latency: a request sampled at edge k gives read_enable high after edge k; the BRAM registers data at edge k+1; o_data and o_data_valid appear after edge k+2. That is 3 cycles from request to data, and at most one word every 3 cycles.
- Full capture of 2**NB_ADDR back-to-back samples takes 2**NB_ADDR cycles after entering CAPTURE.

## Test plan
Bench uses NB_ADDR=3 and NB_DATA=14, with a behavioural BRAM model attached.
- Full capture: i_start, then 8 consecutive valid samples 0x0010..0x0017 -> writes to addresses 0..7 with matching data; FULL entered after the 8th; o_count=8; o_busy falls; the 9th valid sample is not written.
- Readback: 8 i_read_req pulses issued whenever o_ready=1 -> o_data returns 0x0010..0x0017 in order; each o_data_valid comes 3 cycles after its request; o_done coincides with the 8th valid; state returns to IDLE.
- Early stop: 3 samples 0x1A, 0x1B, 0x1C, with i_stop asserted together with the third -> o_count=3; readback returns exactly 0x1A, 0x1B, 0x1C, then o_done.
- Empty stop: i_start followed immediately by i_stop with no valid samples -> o_done pulses; no write strobe occurs; state IDLE; o_count=0.
- Ignored and in-flight events:
  - i_read_req held high during RD_ISSUE/RD_WAIT -> exactly one read per FULL visit.
  - i_start during CAPTURE -> no pointer reset.
- Reset mid-operation: i_reset asserted after the 4th write, then again during RD_WAIT -> all outputs are 0 on the next cycle; no o_data_valid appears; a fresh i_start restarts at address 0.
